add_arbiter: RTL and testbench
==============================

ADD_ARBITER -- requirements
Module: add_arbiter

Interface
REQ-001 Parameter: N, 32, operand/result width in bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 req0_a, req0_b  input  N each  requester 0 operands.
REQ-007 req0_sub  input  1  requester 0 op: 0 = a+b, 1 = a-b.
REQ-008 req1_valid, req1_ready, req1_a, req1_b, req1_sub: same as REQ-004..007 for requester 1.
REQ-009 res_valid  output  1  result held and valid.
REQ-010 res_ready  input  1  consumer takes result this cycle.
REQ-011 res_sum  output  N  registered sum/difference.
REQ-012 res_cout  output  1  registered carry-out of the N-bit adder.
REQ-013 res_ovf  output  1  registered signed overflow.
REQ-014 res_id  output  1  requester that owns the result.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 The FSM SHALL have three states: IDLE, CALC, DONE.
REQ-017 IDLE: if any reqX_valid, grant one, pulse its reqX_ready for exactly that cycle, latch a, b, sub and id, then go to CALC.
REQ-018 Arbitration SHALL be round-robin: on a simultaneous request, grant the requester that was not last granted. A single request is always granted.
REQ-019 The last-granted register SHALL update only on a grant.
REQ-020 CALC: drive the adder with a, (sub ? ~b : b) and c_in = sub. Register sum, cout and ovf. Go to DONE.
REQ-021 ovf SHALL equal (a[N-1] == b_eff[N-1]) && (sum[N-1] != a[N-1]), where b_eff is the inverted-or-not operand.
REQ-022 DONE: res_valid = 1, and res_sum/cout/ovf/id SHALL stay stable until res_ready = 1.
REQ-023 When res_ready = 1 in DONE, return to IDLE. No new grant in that same cycle; minimum issue interval is 3 cycles.
REQ-024 Latency: grant at edge k, res_valid high from edge k+2.
REQ-025 reqX_ready SHALL be 0 in CALC and DONE; requests presented then are held off, not dropped.
REQ-026 Widths: sum is N bits modulo 2^N. For sub, cout = 1 means no borrow.
REQ-027 A requester deasserting valid while not granted SHALL have no effect.

Reset
REQ-028 When rst_n = 0: state = IDLE; res_valid, reqX_ready and busy = 0; res_sum = 0, res_cout = 0, res_ovf = 0, res_id = 0; last-granted = 1, so requester 0 wins first. These values SHALL be immediate, without waiting for clk.
REQ-029 Reset in CALC or DONE SHALL discard the in-flight operation; no result is produced after release.
REQ-030 Operation SHALL resume on the first rising edge after rst_n rises.

Structure
REQ-031 A shared package SHALL hold the state enum (IDLE/CALC/DONE) and the requester-id constants REQ0 = 0 and REQ1 = 1.
REQ-032 The arithmetic SHALL be one instance of the team's N-bit ripple-carry adder FA, with N passed through. No other adder logic.
REQ-033 Operand inversion, the overflow term and the arbiter SHALL live in add_arbiter.

Verification
REQ-034 Reset, then req0 a=5, b=3, sub=0 → req0_ready pulses; 2 cycles later res_sum=8, cout=0, ovf=0, id=0.
REQ-035 Both valid at once from reset, req0 5-3, req1 0x7FFFFFFF+1 → req0 served first: res_sum=2, cout=1. Then req1: res_sum=0x80000000, ovf=1, id=1.
REQ-036 Both valid continuously for 4 ops → grants alternate 0,1,0,1.
REQ-037 req1 0xFFFFFFFF+1 with res_ready low for 5 cycles → res_sum=0, cout=1, outputs stable throughout; req0 held off with req0_ready=0.
REQ-038 rst_n low during CALC → res_valid stays 0 and busy drops immediately; the next request gets a fresh result.
REQ-039 req0 sub: 0-1 → res_sum=0xFFFFFFFF, cout=0, ovf=0.

Source files
------------

// File: rtl/add_arbiter_pkg.sv
// Shared types and constants for the two-requester add/subtract arbiter.
package add_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/add_arbiter_fa.sv
// N-bit ripple-carry adder: the carry propagates bit by bit from cin to cout.
module FA #(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic carry;

    // Walking one carry variable keeps the ripple chain free of a combinational vector loop.
    always_comb begin
        carry = cin;
        sum   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/add_arbiter.sv
// Round-robin arbiter sharing one ripple-carry adder between two requesters;
// each operation runs IDLE (grant) -> CALC (register result) -> DONE (hold until taken).
module add_arbiter
    import add_arbiter_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic         req0_sub,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    input  logic         req1_sub,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [N-1:0] res_sum,
    output logic         res_cout,
    output logic         res_ovf,
    output logic         res_id,
    output logic         busy
);

    state_t       state;
    state_t       state_next;
    logic         last_grant;
    logic         grant_any;
    logic         grant_id;
    logic [N-1:0] op_a;
    logic [N-1:0] op_b;
    logic         op_sub;
    logic         op_id;
    logic [N-1:0] b_eff;
    logic [N-1:0] add_sum;
    logic         add_cout;
    logic         add_ovf;

    // Grant is gated by rst_n so the ready pulses are low for the whole reset, not just after an edge.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = REQ0;
        if (rst_n && state == IDLE) begin
            if (req0_valid && req1_valid) begin
                grant_any = 1'b1;
                grant_id  = ~last_grant;
            end else if (req0_valid) begin
                grant_any = 1'b1;
                grant_id  = REQ0;
            end else if (req1_valid) begin
                grant_any = 1'b1;
                grant_id  = REQ1;
            end
        end
    end

    assign req0_ready = grant_any && (grant_id == REQ0);
    assign req1_ready = grant_any && (grant_id == REQ1);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_any) state_next = CALC;
            CALC:    state_next = DONE;
            DONE:    if (res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign b_eff   = op_sub ? ~op_b : op_b;
    assign add_ovf = (op_a[N-1] == b_eff[N-1]) && (add_sum[N-1] != op_a[N-1]);

    FA #(.N(N)) u_fa (
        .a    (op_a),
        .b    (b_eff),
        .cin  (op_sub),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= REQ1;
            op_a       <= '0;
            op_b       <= '0;
            op_sub     <= 1'b0;
            op_id      <= REQ0;
            res_sum    <= '0;
            res_cout   <= 1'b0;
            res_ovf    <= 1'b0;
            res_id     <= REQ0;
        end else begin
            state <= state_next;
            if (grant_any) begin
                last_grant <= grant_id;
                op_id      <= grant_id;
                op_a       <= (grant_id == REQ1) ? req1_a   : req0_a;
                op_b       <= (grant_id == REQ1) ? req1_b   : req0_b;
                op_sub     <= (grant_id == REQ1) ? req1_sub : req0_sub;
            end
            if (state == CALC) begin
                res_sum  <= add_sum;
                res_cout <= add_cout;
                res_ovf  <= add_ovf;
                res_id   <= op_id;
            end
        end
    end

    assign res_valid = (state == DONE);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_add_arbiter.sv
// Directed self-checking bench for add_arbiter: reset, latency, round-robin, hold-off and abort.
module tb_add_arbiter;

    localparam int unsigned N = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req0_ready, req0_sub;
    logic         req1_valid, req1_ready, req1_sub;
    logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         res_valid, res_ready, res_cout, res_ovf, res_id, busy;
    logic [N-1:0] res_sum;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    add_arbiter #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_sub   (req0_sub),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_sub   (req1_sub),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_sum    (res_sum),
        .res_cout   (res_cout),
        .res_ovf    (res_ovf),
        .res_id     (res_id),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_result(input string tag, input logic [31:0] sum, input logic cout,
                                input logic ovf, input logic id);
        check({tag, "_valid"}, 32'(res_valid), 32'd1);
        check({tag, "_sum"},   res_sum,        sum);
        check({tag, "_cout"},  32'(res_cout),  32'(cout));
        check({tag, "_ovf"},   32'(res_ovf),   32'(ovf));
        check({tag, "_id"},    32'(res_id),    32'(id));
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst_n      = 1'b0;
        req0_valid = 1'b1;
        req0_a     = 32'd5;
        req0_b     = 32'd3;
        req0_sub   = 1'b0;
        req1_valid = 1'b0;
        req1_a     = '0;
        req1_b     = '0;
        req1_sub   = 1'b0;
        res_ready  = 1'b0;

        // Reset values, with a request already pending
        #1;
        check("rst_ready0", 32'(req0_ready), 32'd0);
        check("rst_valid",  32'(res_valid),  32'd0);
        check("rst_busy",   32'(busy),       32'd0);
        check("rst_sum",    res_sum,         32'd0);
        check("rst_cout",   32'(res_cout),   32'd0);
        check("rst_ovf",    32'(res_ovf),    32'd0);
        check("rst_id",     32'(res_id),     32'd0);
        req0_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single request 5 + 3
        req0_valid = 1'b1;
        #1;
        check("t1_ready0", 32'(req0_ready), 32'd1);
        check("t1_ready1", 32'(req1_ready), 32'd0);
        @(negedge clk);
        req0_valid = 1'b0;
        check("t1_calc_busy",  32'(busy),      32'd1);
        check("t1_calc_valid", 32'(res_valid), 32'd0);
        @(negedge clk);
        check_result("t1", 32'd8, 1'b0, 1'b0, 1'b0);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("t1_idle_busy",  32'(busy),      32'd0);
        check("t1_idle_valid", 32'(res_valid), 32'd0);

        // Simultaneous requests from reset: req0 5-3 first, then req1 0x7FFFFFFF+1
        apply_reset();
        req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd3; req0_sub = 1'b1;
        req1_valid = 1'b1; req1_a = 32'h7FFF_FFFF; req1_b = 32'd1; req1_sub = 1'b0;
        #1;
        check("t2_first_ready0", 32'(req0_ready), 32'd1);
        check("t2_first_ready1", 32'(req1_ready), 32'd0);
        @(negedge clk);
        req0_valid = 1'b0;
        check("t2_calc_ready1", 32'(req1_ready), 32'd0);
        @(negedge clk);
        check("t2_done_ready1", 32'(req1_ready), 32'd0);
        check_result("t2_r0", 32'd2, 1'b1, 1'b0, 1'b0);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        #1;
        check("t2_second_ready1", 32'(req1_ready), 32'd1);
        @(negedge clk);
        req1_valid = 1'b0;
        @(negedge clk);
        check_result("t2_r1", 32'h8000_0000, 1'b0, 1'b1, 1'b1);
        res_ready = 1'b1;
        @(negedge clk);

        // Both valid continuously, consumer always ready: 0,1,0,1
        req0_valid = 1'b1; req0_a = 32'd10;  req0_b = 32'd20; req0_sub = 1'b0;
        req1_valid = 1'b1; req1_a = 32'd100; req1_b = 32'd1;  req1_sub = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("t3_ready0", 32'(req0_ready), 32'((k % 2) == 0));
            check("t3_ready1", 32'(req1_ready), 32'((k % 2) == 1));
            @(negedge clk);
            check("t3_busy", 32'(busy), 32'd1);
            @(negedge clk);
            if ((k % 2) == 0) check_result("t3_r0", 32'd30, 1'b0, 1'b0, 1'b0);
            else              check_result("t3_r1", 32'd99, 1'b1, 1'b0, 1'b1);
            @(negedge clk);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        res_ready  = 1'b0;
        @(negedge clk);

        // req1 0xFFFFFFFF+1 held in DONE for 5 cycles; req0 held off meanwhile
        req1_valid = 1'b1; req1_a = 32'hFFFF_FFFF; req1_b = 32'd1; req1_sub = 1'b0;
        #1;
        check("t4_ready1", 32'(req1_ready), 32'd1);
        @(negedge clk);
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_a = 32'd7; req0_b = 32'd7; req0_sub = 1'b0;
        check("t4_calc_ready0", 32'(req0_ready), 32'd0);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            check_result("t4_hold", 32'd0, 1'b1, 1'b0, 1'b1);
            check("t4_hold_ready0", 32'(req0_ready), 32'd0);
            @(negedge clk);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        #1;
        check("t4_heldoff_ready0", 32'(req0_ready), 32'd1);
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        check_result("t4_r0", 32'd14, 1'b0, 1'b0, 1'b0);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;

        // Reset during CALC aborts the operation
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2; req0_sub = 1'b0;
        @(negedge clk);
        req0_valid = 1'b0;
        check("t5_calc_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_busy",  32'(busy),      32'd0);
        check("t5_rst_valid", 32'(res_valid), 32'd0);
        check("t5_rst_sum",   res_sum,        32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("t5_no_result", 32'(res_valid), 32'd0);
        end

        // Fresh request after abort: 0 - 1
        req0_valid = 1'b1; req0_a = 32'd0; req0_b = 32'd1; req0_sub = 1'b1;
        #1;
        check("t6_ready0", 32'(req0_ready), 32'd1);
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        check_result("t6", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("t6_idle_busy", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
